ex_div: RTL and testbench

- Multi-cycle 32-bit integer divider in the EX stage. Executes MIPS DIV and DIVU and produces the HI (remainder) and LO (quotient) values.
- It is the requester side of the pipeline stall interface. While a divide is in flight it drives stall_req, which is wired to the stall controller's stall_ex input; the controller then freezes PC/IF/ID/EX.
- A flush from the controller or hazard logic aborts an in-flight divide.

---
 rtl/ex_div_if.sv | 24 ++
 rtl/ex_div.sv | 126 ++++++++++++
 tb/tb_ex_div.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// Handshake and operand/result bundle between the EX-stage issue logic and the divider.
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             annul;
    logic             stall_req;
    logic             ready;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;

    modport master (
        output start, signed_div, dividend, divisor, annul,
        input  stall_req, ready, result_lo, result_hi
    );

    modport slave (
        input  start, signed_div, dividend, divisor, annul,
        output stall_req, ready, result_lo, result_hi
    );
endinterface

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, producing HI (remainder) and LO (quotient).
module ex_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     clr,
    ex_div_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BYZERO = 2'd1;
    localparam logic [1:0] BUSY   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic             ready_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;

    // Datapath: quo starts as |dividend| and fills with quotient bits from the LSB side.
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic             is_signed;
    logic             neg_a;
    logic             neg_b;

    logic [WIDTH+1:0] shifted;
    logic             q_bit;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             abort;
    logic             divisor_zero;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        q_bit    = (shifted >= {2'b00, dvs});
        rem_next = q_bit ? (WIDTH+1)'(shifted - {2'b00, dvs}) : shifted[WIDTH:0];
        quo_next = {quo[WIDTH-2:0], q_bit};
    end

    assign abort        = bus.annul | ~bus.start;
    assign divisor_zero = (bus.divisor == '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            counter <= '0;
            ready_r <= 1'b0;
            lo_r    <= '0;
            hi_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_r <= 1'b0;
                    if (bus.start && !bus.annul && !divisor_zero) begin
                        state   <= BUSY;
                        counter <= '0;
                    end else if (bus.start && divisor_zero) begin
                        state <= BYZERO;
                    end
                end
                BYZERO: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        state   <= DONE;
                        ready_r <= 1'b1;
                        lo_r    <= '1;
                        hi_r    <= quo;
                    end
                end
                BUSY: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        counter <= counter + CNT_W'(1);
                        if (counter == LAST) begin
                            state   <= DONE;
                            ready_r <= 1'b1;
                            lo_r    <= negate_if(quo_next, is_signed & (neg_a ^ neg_b));
                            hi_r    <= negate_if(rem_next[WIDTH-1:0], is_signed & neg_a);
                        end
                    end
                end
                default: begin
                    // DONE: hold the result until the instruction leaves EX.
                    if (abort) begin
                        state   <= IDLE;
                        ready_r <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Operand latch and iteration registers carry no reset; state gates their use.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            quo       <= divisor_zero ? bus.dividend : abs_val(bus.dividend, bus.signed_div);
            dvs       <= abs_val(bus.divisor, bus.signed_div);
            rem       <= '0;
            is_signed <= bus.signed_div;
            neg_a     <= bus.dividend[WIDTH-1];
            neg_b     <= bus.divisor[WIDTH-1];
        end else if (state == BUSY) begin
            quo <= quo_next;
            rem <= rem_next;
        end
    end

    assign bus.stall_req = bus.start & ~bus.annul & (state != DONE);
    assign bus.ready     = ready_r;
    assign bus.result_lo = lo_r;
    assign bus.result_hi = hi_r;
endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed vector table, corner sequences and randomized divides.
module tb_ex_div;
    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   passed = 0;

    ex_div_if #(.WIDTH(32)) bus();
    ex_div #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .clr(clr), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    // Reference: MIPS DIV/DIVU semantics from plain arithmetic.
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
        int sa;
        int sb;
        if (b == 0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (!sgn) begin
            lo = a / b;
            hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'h0;
        end else begin
            sa = a;
            sb = b;
            lo = sa / sb;
            hi = sa % sb;
        end
    endfunction

    // Issue a divide at cycle 0 and wait for ready; optionally scramble operands at chg_cycle.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int chg_cycle, output int rdy_cyc, output int stalls);
        bus.start      = 1'b1;
        bus.signed_div = sgn;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.annul      = 1'b0;
        #1;
        rdy_cyc = 0;
        stalls  = 0;
        while (!bus.ready && rdy_cyc < 200) begin
            if (bus.stall_req) stalls++;
            @(posedge clk);
            #2;
            rdy_cyc++;
            if (rdy_cyc == chg_cycle) begin
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
                #1;
            end
        end
        if (!bus.ready) begin
            total++;
            $display("FAIL timeout: ready not seen after %0d cycles, required within 200", rdy_cyc);
        end
    endtask

    task automatic drop_start();
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        check("ready_after_drop", {31'b0, bus.ready}, 32'd0);
    endtask

    initial begin
        int          rc;
        int          st;
        logic [31:0] elo;
        logic [31:0] ehi;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
        vecs[5] = '{1'b0, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       2};

        clr = 1'b1;
        bus.start = 1'b0;
        bus.signed_div = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        bus.annul = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check("reset_ready", {31'b0, bus.ready}, 32'd0);
        check("reset_lo", bus.result_lo, 32'd0);
        check("reset_hi", bus.result_hi, 32'd0);
        check("reset_stall", {31'b0, bus.stall_req}, 32'd0);
        @(posedge clk);
        #2;

        for (int i = 0; i < 6; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, 0, rc, st);
            check($sformatf("vec%0d_lo", i), bus.result_lo, vecs[i].lo);
            check($sformatf("vec%0d_hi", i), bus.result_hi, vecs[i].hi);
            check($sformatf("vec%0d_latency", i), rc, vecs[i].lat);
            check($sformatf("vec%0d_stall_cycles", i), st, vecs[i].lat);
            if (i == 0) begin
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #2;
                    check("hold_ready", {31'b0, bus.ready}, 32'd1);
                    check("hold_stall", {31'b0, bus.stall_req}, 32'd0);
                    check("hold_lo", bus.result_lo, 32'd14);
                end
            end
            drop_start();
        end

        // Annul in the tenth BUSY cycle, then re-issue.
        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.dividend = 32'd100;
        bus.divisor = 32'd7;
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        bus.annul = 1'b1;
        #1;
        check("annul_stall", {31'b0, bus.stall_req}, 32'd0);
        @(posedge clk);
        #2;
        bus.annul = 1'b0;
        bus.start = 1'b0;
        #1;
        check("annul_ready", {31'b0, bus.ready}, 32'd0);
        check("annul_stall_after", {31'b0, bus.stall_req}, 32'd0);
        check("annul_lo_kept", bus.result_lo, 32'hFFFF_FFFF);
        @(posedge clk);
        #2;
        check("annul_idle_ready", {31'b0, bus.ready}, 32'd0);
        run_div(1'b0, 32'd50, 32'd5, 0, rc, st);
        check("reissue_lo", bus.result_lo, 32'd10);
        check("reissue_hi", bus.result_hi, 32'd0);
        check("reissue_latency", rc, 33);
        drop_start();

        // Reset in the middle of a divide.
        bus.start = 1'b1;
        bus.dividend = 32'd999;
        bus.divisor = 32'd4;
        repeat (6) begin
            @(posedge clk);
            #2;
        end
        clr = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        check("clr_ready", {31'b0, bus.ready}, 32'd0);
        check("clr_lo", bus.result_lo, 32'd0);
        check("clr_hi", bus.result_hi, 32'd0);
        check("clr_stall", {31'b0, bus.stall_req}, 32'd0);
        clr = 1'b0;
        @(posedge clk);
        #2;

        // Operands scrambled mid-BUSY must not affect the result.
        run_div(1'b0, 32'd1000, 32'd3, 5, rc, st);
        check("latched_lo", bus.result_lo, 32'd333);
        check("latched_hi", bus.result_hi, 32'd1);
        check("latched_latency", rc, 33);
        drop_start();

        // Start dropped mid-BUSY aborts.
        bus.start = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor = 32'd3;
        repeat (4) begin
            @(posedge clk);
            #2;
        end
        bus.start = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #2;
        end
        check("drop_abort_ready", {31'b0, bus.ready}, 32'd0);
        check("drop_abort_lo", bus.result_lo, 32'd333);

        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom % 2);
            a = $urandom;
            if (i % 7 == 3) b = 32'd0;
            else if ($urandom % 4 == 0) b = $urandom % 16;
            else b = $urandom;
            if (i % 5 == 1) a = 32'h8000_0000;
            model(sgn, a, b, elo, ehi);
            run_div(sgn, a, b, 0, rc, st);
            check($sformatf("rand%0d_lo", i), bus.result_lo, elo);
            check($sformatf("rand%0d_hi", i), bus.result_hi, ehi);
            check($sformatf("rand%0d_latency", i), rc, (b == 0) ? 2 : 33);
            drop_start();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
